// File: rtl/switch_merge.sv
// switch_merge: buffers ports A and B in per-port FIFOs and round-robin merges them onto one registered valid/ready stream
module switch_merge #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vld_a,
  input  logic [ADDR_W-1:0]      addr_a,
  input  logic [DATA_W-1:0]      data_a,
  output logic                   rdy_a,
  input  logic                   vld_b,
  input  logic [ADDR_W-1:0]      addr_b,
  input  logic [DATA_W-1:0]      data_b,
  output logic                   rdy_b,
  output logic                   vld,
  output logic [ADDR_W-1:0]      addr,
  output logic [DATA_W-1:0]      data,
  output logic                   src,
  input  logic                   rdy,
  output logic [$clog2(DEPTH):0] cnt_a,
  output logic [$clog2(DEPTH):0] cnt_b
);
  localparam int PW = $clog2(DEPTH);
  localparam int BW = ADDR_W + DATA_W;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  logic [1:0] vin, wr, pop, ne, rdy_in;
  logic [BW-1:0] din [2];
  logic [BW-1:0] head [2];
  logic [PW:0] cnt [2];
  logic ld, gnt;
  logic vld_q, vld_d, src_q, src_d, last_q, last_d;
  logic [BW-1:0] beat_q, beat_d;
  assign vin = {vld_b, vld_a};
  assign din[0] = {addr_a, data_a};
  assign din[1] = {addr_b, data_b};
  assign {rdy_b, rdy_a} = rdy_in;
  assign cnt_a = cnt[0];
  assign cnt_b = cnt[1];
  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [BW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [PW:0] cnt_q;
    assign rdy_in[g] = (cnt_q != FULL) && !rst;
    assign wr[g] = vin[g] && rdy_in[g];
    assign ne[g] = cnt_q != '0;
    assign head[g] = mem_q[rp_q];
    assign cnt[g] = cnt_q;
    // storage is unreset; only entries covered by the occupancy count are ever read
    always_ff @(posedge clk)
      if (wr[g]) mem_q[wp_q] <= din[g];
    // pointers and occupancy; registered count means a fresh write is not visible to the arbiter until next cycle
    always_ff @(posedge clk)
      if (rst) begin
        wp_q  <= '0;
        rp_q  <= '0;
        cnt_q <= '0;
      end else begin
        wp_q  <= wp_q + PW'(wr[g]);
        rp_q  <= rp_q + PW'(pop[g]);
        cnt_q <= cnt_q + (PW+1)'(wr[g]) - (PW+1)'(pop[g]);
      end
  end
  assign ld  = (!vld_q || rdy) && |ne;
  assign gnt = &ne ? !last_q : ne[1];
  assign pop = {ld && gnt, ld && !gnt};
  // output register next state: load granted head when free, else hold or drain
  always_comb begin
    vld_d  = (!vld_q || rdy) ? |ne : vld_q;
    beat_d = ld ? head[gnt] : beat_q;
    src_d  = ld ? gnt : src_q;
    last_d = ld ? gnt : last_q;
  end
  // output register; last grant starts at B so the first contention favours A
  always_ff @(posedge clk)
    if (rst) begin
      vld_q  <= 1'b0;
      beat_q <= '0;
      src_q  <= 1'b0;
      last_q <= 1'b1;
    end else begin
      vld_q  <= vld_d;
      beat_q <= beat_d;
      src_q  <= src_d;
      last_q <= last_d;
    end
  assign vld = vld_q;
  assign {addr, data} = beat_q;
  assign src = src_q;
endmodule

// File: tb/tb_switch_merge.sv
// tb_switch_merge: directed and scoreboarded checks of the two-port merge
module tb_switch_merge;
  logic clk = 1'b0;
  logic rst, vld_a, vld_b, rdy, rdy_a, rdy_b, vld, src;
  logic [7:0] addr_a, addr_b, addr;
  logic [15:0] data_a, data_b, data;
  logic [2:0] cnt_a, cnt_b;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  switch_merge dut (
    .clk(clk), .rst(rst),
    .vld_a(vld_a), .addr_a(addr_a), .data_a(data_a), .rdy_a(rdy_a),
    .vld_b(vld_b), .addr_b(addr_b), .data_b(data_b), .rdy_b(rdy_b),
    .vld(vld), .addr(addr), .data(data), .src(src), .rdy(rdy),
    .cnt_a(cnt_a), .cnt_b(cnt_b)
  );
  task automatic tick;
    @(negedge clk);
  endtask
  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1; rdy = 1'b0;
    vld_a = 1'b1; addr_a = 8'h11; data_a = 16'h1111;
    vld_b = 1'b1; addr_b = 8'h22; data_b = 16'h2222;
    tick();
    tick();
    n_cmp++; if ({rdy_a, rdy_b} !== 2'b00) begin n_err++; $display("FAIL reset_rdy: got %b exp 00", {rdy_a, rdy_b}); end
    n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b exp 0", vld); end
    n_cmp++; if ({cnt_a, cnt_b} !== 6'd0) begin n_err++; $display("FAIL reset_cnt: got %0d/%0d exp 0/0", cnt_a, cnt_b); end
    n_cmp++; if ({addr, data, src} !== 25'd0) begin n_err++; $display("FAIL reset_out: got %h %h %b exp 0", addr, data, src); end
    rst = 1'b0; vld_a = 1'b0; vld_b = 1'b0;
    #1;
    n_cmp++; if ({rdy_a, rdy_b} !== 2'b11) begin n_err++; $display("FAIL post_reset_rdy: got %b exp 11", {rdy_a, rdy_b}); end
    tick();
  endtask
  task automatic test_single;
    rdy = 1'b1;
    vld_a = 1'b1; addr_a = 8'h12; data_a = 16'hBEEF;
    tick();
    vld_a = 1'b0;
    n_cmp++; if (vld !== 1'b0 || cnt_a !== 3'd1) begin n_err++; $display("FAIL single_no_bypass: got vld=%b cnt_a=%0d exp vld=0 cnt_a=1", vld, cnt_a); end
    tick();
    n_cmp++; if ({vld, addr, data, src} !== {1'b1, 8'h12, 16'hBEEF, 1'b0}) begin n_err++; $display("FAIL single_beat: got %b %h %h %b exp 1 12 beef 0", vld, addr, data, src); end
    n_cmp++; if (cnt_a !== 3'd0) begin n_err++; $display("FAIL single_pop: got cnt_a=%0d exp 0", cnt_a); end
    tick();
    n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL single_drain: got vld=%b exp 0", vld); end
  endtask
  task automatic test_interleave;
    logic [7:0] ea;
    logic [15:0] ed;
    do_reset();
    rdy = 1'b1;
    for (int c = 0; c < 11; c++) begin
      vld_a = c < 4; addr_a = 8'hA0 + 8'(c); data_a = 16'hA000 + 16'(c);
      vld_b = c < 4; addr_b = 8'hB0 + 8'(c); data_b = 16'hB000 + 16'(c);
      if (c >= 2 && c < 10) begin
        ea = ((c - 2) % 2) ? 8'hB0 + 8'((c - 2) / 2) : 8'hA0 + 8'((c - 2) / 2);
        ed = ((c - 2) % 2) ? 16'hB000 + 16'((c - 2) / 2) : 16'hA000 + 16'((c - 2) / 2);
        n_cmp++; if ({vld, addr, data, src} !== {1'b1, ea, ed, 1'((c - 2) % 2)}) begin n_err++; $display("FAIL interleave_%0d: got %b %h %h %b exp 1 %h %h %0d", c - 2, vld, addr, data, src, ea, ed, (c - 2) % 2); end
      end else begin
        n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL interleave_idle_%0d: got vld=%b exp 0", c, vld); end
      end
      tick();
    end
  endtask
  task automatic test_capacity;
    logic acc;
    rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vld_a = 1'b1; addr_a = 8'hC0 + 8'(i); data_a = 16'hD000 + 16'(i);
      n_cmp++; if (rdy_a !== (i < 5)) begin n_err++; $display("FAIL capacity_rdy_%0d: got %b exp %b", i, rdy_a, i < 5); end
      tick();
    end
    n_cmp++; if (cnt_a !== 3'd4 || rdy_a !== 1'b0) begin n_err++; $display("FAIL capacity_full: got cnt_a=%0d rdy_a=%b exp 4 0", cnt_a, rdy_a); end
    n_cmp++; if ({vld, addr, data, src} !== {1'b1, 8'hC0, 16'hD000, 1'b0}) begin n_err++; $display("FAIL capacity_hold: got %b %h %h %b exp 1 c0 d000 0", vld, addr, data, src); end
    rdy = 1'b1;
    for (int k = 1; k < 6; k++) begin
      acc = vld_a && rdy_a;
      tick();
      if (acc) vld_a = 1'b0;
      n_cmp++; if ({vld, addr, data, src} !== {1'b1, 8'hC0 + 8'(k), 16'hD000 + 16'(k), 1'b0}) begin n_err++; $display("FAIL capacity_out_%0d: got %b %h %h %b exp 1 %h %h 0", k, vld, addr, data, src, 8'hC0 + 8'(k), 16'hD000 + 16'(k)); end
    end
    vld_a = 1'b0;
    tick();
    n_cmp++; if (vld !== 1'b0 || cnt_a !== 3'd0) begin n_err++; $display("FAIL capacity_drain: got vld=%b cnt_a=%0d exp 0 0", vld, cnt_a); end
  endtask
  task automatic test_reset_mid;
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vld_a = 1'b1; addr_a = 8'hE0 + 8'(i); data_a = 16'hE000 + 16'(i);
      tick();
    end
    vld_a = 1'b0;
    n_cmp++; if (cnt_a !== 3'd3 || vld !== 1'b1) begin n_err++; $display("FAIL mid_prefill: got cnt_a=%0d vld=%b exp 3 1", cnt_a, vld); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({rdy_a, rdy_b} !== 2'b00) begin n_err++; $display("FAIL mid_rst_rdy: got %b exp 00", {rdy_a, rdy_b}); end
    tick();
    rst = 1'b0;
    n_cmp++; if (vld !== 1'b0 || cnt_a !== 3'd0 || cnt_b !== 3'd0) begin n_err++; $display("FAIL mid_flush: got vld=%b cnt=%0d/%0d exp 0 0/0", vld, cnt_a, cnt_b); end
    rdy = 1'b1;
    vld_a = 1'b1; addr_a = 8'h55; data_a = 16'h5555;
    tick();
    vld_a = 1'b0;
    n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL mid_stale: got vld=%b addr=%h exp vld=0", vld, addr); end
    tick();
    n_cmp++; if ({vld, addr, data, src} !== {1'b1, 8'h55, 16'h5555, 1'b0}) begin n_err++; $display("FAIL mid_post: got %b %h %h %b exp 1 55 5555 0", vld, addr, data, src); end
    tick();
    n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL mid_only_post: got vld=%b addr=%h exp vld=0", vld, addr); end
  endtask
  task automatic test_random;
    logic [23:0] qa[$];
    logic [23:0] qb[$];
    logic [23:0] e;
    logic pv = 1'b0, pr = 1'b0, ps = 1'b0;
    logic [7:0] pa = '0;
    logic [15:0] pd = '0;
    int na = 0, nb = 0;
    for (int c = 0; c < 2100; c++) begin
      bit drive;
      drive = c < 2000;
      if (pv && !pr) begin
        n_cmp++; if ({vld, src, addr, data} !== {1'b1, ps, pa, pd}) begin n_err++; $display("FAIL rand_stall_%0d: got %b %b %h %h exp 1 %b %h %h", c, vld, src, addr, data, ps, pa, pd); end
      end
      n_cmp++; if (cnt_a > 3'd4 || cnt_b > 3'd4) begin n_err++; $display("FAIL rand_cnt_%0d: got %0d/%0d exp <=4", c, cnt_a, cnt_b); end
      vld_a = drive && ($urandom_range(0, 2) != 0);
      vld_b = drive && ($urandom_range(0, 2) != 0);
      addr_a = 8'($urandom); data_a = 16'(na);
      addr_b = 8'($urandom); data_b = 16'h8000 | 16'(nb);
      rdy = !drive || ($urandom_range(0, (c < 1000) ? 1 : 3) != 0);
      if (vld_a && rdy_a) begin qa.push_back({addr_a, data_a}); na++; end
      if (vld_b && rdy_b) begin qb.push_back({addr_b, data_b}); nb++; end
      if (vld && rdy) begin
        n_cmp++;
        if (src ? qb.size() == 0 : qa.size() == 0) begin
          n_err++; $display("FAIL rand_extra_%0d: got beat %h %h src=%b exp none", c, addr, data, src);
        end else begin
          e = src ? qb.pop_front() : qa.pop_front();
          if ({addr, data} !== e) begin n_err++; $display("FAIL rand_order_%0d: got %h %h src=%b exp %h %h", c, addr, data, src, e[23:16], e[15:0]); end
        end
      end
      pv = vld; pr = rdy; ps = src; pa = addr; pd = data;
      tick();
    end
    n_cmp++; if (qa.size() != 0 || qb.size() != 0) begin n_err++; $display("FAIL rand_loss: got %0d/%0d undelivered exp 0/0", qa.size(), qb.size()); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_interleave();
    test_capacity();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
